// File: rtl/vreg_writeback.sv
// Vector register file write-back: accepts an aligned group of 1/2/4/8 results
// and retires them into the register file one register per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a request; misaligned or reserved requests pulse wr_err
// S_WRITE | buffered group being written, one register per cycle
module vreg_writeback #(
    parameter int REG_W    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4:0]                wr_sel,
    input  logic [2:0]                wr_vlmul,
    input  logic [8*REG_W-1:0]        wr_data,
    output logic [REG_W*NUM_REGS-1:0] registers,
    output logic                      busy,
    output logic                      wr_done,
    output logic                      wr_err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [8*REG_W-1:0] r_buf;
    logic [4:0]         r_base;
    logic [2:0]         r_idx;
    logic [2:0]         r_last;
    logic               r_done;
    logic               r_err;
    logic [REG_W-1:0]   r_regs [NUM_REGS];

    logic [2:0]         w_align_mask;
    logic               w_req_ok;
    logic               w_accept;
    logic               w_last;
    logic               w_we;
    logic [4:0]         w_wr_reg;
    logic [REG_W-1:0]   w_wr_word;

    // The alignment mask doubles as N-1 for the group, so it is latched as r_last.
    always_comb begin
        w_align_mask = 3'd0;
        case (wr_vlmul)
            3'd0:    w_align_mask = 3'd0;
            3'd1:    w_align_mask = 3'd1;
            3'd2:    w_align_mask = 3'd3;
            3'd3:    w_align_mask = 3'd7;
            default: w_align_mask = 3'd0;
        endcase
    end

    assign w_req_ok = ~wr_vlmul[2] && ((wr_sel[2:0] & w_align_mask) == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_req_ok) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (r_state == S_IDLE) && !rst;
        busy     = (r_state == S_WRITE);
        w_accept = wr_valid && wr_ready;
        w_we     = (r_state == S_WRITE);
        w_last   = w_we && (r_idx == r_last);
    end

    // Base is aligned to the group size, so base+idx never carries past the group.
    assign w_wr_reg  = r_base + {2'b00, r_idx};
    assign w_wr_word = r_buf[int'(r_idx)*REG_W +: REG_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf  <= '0;
            r_base <= '0;
            r_idx  <= '0;
            r_last <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_done <= w_last;
            r_err  <= w_accept && !w_req_ok;
            if (w_accept && w_req_ok) begin
                r_buf  <= wr_data;
                r_base <= wr_sel;
                r_last <= w_align_mask;
                r_idx  <= '0;
            end
            if (w_we) begin
                r_regs[w_wr_reg] <= w_wr_word;
                r_idx            <= r_idx + 3'd1;
            end
        end
    end

    assign wr_done = r_done;
    assign wr_err  = r_err;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign registers[k*REG_W +: REG_W] = r_regs[k];
    end

endmodule

// File: tb/tb_vreg_writeback.sv
// Randomized bench for vreg_writeback against a queue-based write-back model.
module tb_vreg_writeback;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_valid;
    logic           wr_ready;
    logic [4:0]     wr_sel;
    logic [2:0]     wr_vlmul;
    logic [255:0]   wr_data;
    logic [1023:0]  registers;
    logic           busy;
    logic           wr_done;
    logic           wr_err;

    always #5 clk = ~clk;

    vreg_writeback #(.REG_W(32), .NUM_REGS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_vlmul  (wr_vlmul),
        .wr_data   (wr_data),
        .registers (registers),
        .busy      (busy),
        .wr_done   (wr_done),
        .wr_err    (wr_err)
    );

    typedef struct {
        int          r;
        logic [31:0] w;
    } wr_t;

    logic [31:0] m_regs [32];
    wr_t         m_q [$];
    bit          exp_done;
    bit          exp_err;
    int          n_vec;
    int          n_err;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: an accepted group becomes a queue of pending (reg, word) writes,
    // one of which retires per clock.
    task automatic model_edge();
        exp_done = 0;
        exp_err  = 0;
        if (rst) begin
            for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
            m_q.delete();
        end else if (m_q.size() != 0) begin
            wr_t e;
            e = m_q.pop_front();
            m_regs[e.r] = e.w;
            if (m_q.size() == 0) exp_done = 1;
        end else if (wr_valid) begin
            int g;
            g = 1 << int'(wr_vlmul);
            if (int'(wr_vlmul) < 4 && (int'(wr_sel) % g) == 0) begin
                for (int i = 0; i < g; i++) begin
                    wr_t e;
                    e.r = int'(wr_sel) + i;
                    e.w = wr_data[32*i +: 32];
                    m_q.push_back(e);
                end
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 32; k++)
            check_val($sformatf("reg%0d", k), registers[32*k +: 32], m_regs[k]);
        check_val("wr_ready", {31'd0, wr_ready}, {31'd0, (m_q.size() == 0) && !rst});
        check_val("busy",     {31'd0, busy},     {31'd0, m_q.size() != 0});
        check_val("wr_done",  {31'd0, wr_done},  {31'd0, exp_done});
        check_val("wr_err",   {31'd0, wr_err},   {31'd0, exp_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_req(logic [4:0] s, logic [2:0] v);
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_vlmul = v;
    endtask

    logic [255:0] latched;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_vlmul = '0;
        wr_data  = '0;
        for (int k = 0; k < 32; k++) m_regs[k] = 32'hx;
        @(negedge clk);
        steps(2);
        rst = 1'b0;
        step();

        // single register
        set_req(5'd5, 3'd0);
        wr_data = '0;
        wr_data[31:0] = 32'hDEADBEEF;
        step();
        wr_valid = 1'b0;
        step();
        check_val("reg5_direct", registers[191:160], 32'hDEADBEEF);
        step();

        // four-register group
        set_req(5'd8, 3'd2);
        wr_data = '0;
        wr_data[127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        wr_valid = 1'b0;
        steps(5);
        check_val("reg11_direct", registers[383:352], 32'h44);

        // eight-register group with inputs scrambled while writing
        set_req(5'd24, 3'd3);
        for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = $urandom;
        latched = wr_data;
        step();
        for (int i = 0; i < 8; i++) begin
            wr_sel   = 5'($urandom);
            wr_vlmul = 3'($urandom);
            wr_data  = {8{$urandom}};
            step();
        end
        wr_valid = 1'b0;
        step();
        for (int i = 0; i < 8; i++)
            check_val($sformatf("top_word%0d", i), registers[768 + 32*i +: 32], latched[32*i +: 32]);

        // rejected requests back to back
        set_req(5'd6, 3'd2);
        step();
        set_req(5'd0, 3'd5);
        step();
        wr_valid = 1'b0;
        step();

        // reset in the middle of a group
        set_req(5'd16, 3'd3);
        wr_data = {8{32'hA5A5_0F0F}};
        step();
        wr_valid = 1'b0;
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(2);
        check_val("reg16_after_rst", registers[543:512], 32'h0);
        set_req(5'd2, 3'd1);
        wr_data = {8{32'h1234_5678}};
        step();
        wr_valid = 1'b0;
        steps(3);

        // valid held across two requests
        set_req(5'd0, 3'd2);
        for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = 32'h100 + i;
        step();
        set_req(5'd4, 3'd1);
        for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = 32'h200 + i;
        steps(4);
        check_val("second_accept_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 1'b0;
        steps(3);
        check_val("reg5_second", registers[191:160], 32'h201);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int s;
            rst      = ($urandom_range(63) == 0);
            wr_valid = ($urandom_range(2) != 0);
            wr_vlmul = ($urandom_range(9) < 8) ? 3'($urandom_range(3)) : 3'($urandom_range(7));
            s = $urandom_range(31);
            if ($urandom_range(4) != 0 && wr_vlmul < 4)
                s = s - (s % (1 << int'(wr_vlmul)));
            wr_sel = 5'(s);
            for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
